// File: rtl/mmio_uart_tx.sv
`default_nettype none

// ============================================================================
// Package : mmio_uart_pkg
// Brief   : Shared MMIO write-port request type used by the data-memory
//           MMIO initiator and its responders.
// Rev     : 1.0  initial release
// ============================================================================
package mmio_uart_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic            enable;   // write request
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] value;
        logic [1:0]      width;    // access size (not used by this responder)
    } mem_write_control_t;

endpackage : mmio_uart_pkg

// ============================================================================
// Module  : mmio_uart_tx
// Brief   : Memory-mapped 8N1 UART transmitter with a transmit FIFO.
//           Register window (16 bytes at BASE_ADDR):
//             0x0 TXDATA  (W: enqueue value[7:0], R: 0)
//             0x4 STATUS  (R: {count[11:8], empty[2], full[1], busy[0]})
//             0x8 DIVISOR (R/W: clocks per bit, 0 written is stored as 1)
//             0xC reserved (W: dropped, R: 0)
// Ports   : clock          - system clock
//           reset          - synchronous, active-high reset
//           mmio_control   - MMIO request (enable/addr/value/width)
//           mmio_r_data    - combinational read data for mmio_control.addr
//           write_complete - combinational write acceptance (back-pressure)
//           tx             - registered serial output, idles high
// Rev     : 1.0  initial release
// ============================================================================
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [XLEN-1:0] BASE_ADDR       = 32'h0003_0000,
    parameter int              FIFO_DEPTH      = 8,
    parameter logic [15:0]     DEFAULT_DIVISOR = 16'd434
) (
    input  logic               clock,
    input  logic               reset,
    input  mem_write_control_t mmio_control,
    output logic [XLEN-1:0]    mmio_r_data,
    output logic               write_complete,
    output logic               tx
);

    localparam int                  c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                  c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0]  c_depth = c_cnt_w'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [7:0]         fifo_mem_q [FIFO_DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q;
    logic [c_ptr_w-1:0] rd_ptr_q;
    logic [c_cnt_w-1:0] count_q;
    logic [15:0]        divisor_q;

    state_t             state_q;
    logic [15:0]        bit_cnt_q;    // cycles left in current bit, minus one
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;
    logic [15:0]        div_act_q;    // divisor frozen for the frame in flight
    logic               tx_q;

    // ------------------------------------------------------------------
    // Decode and handshake
    // ------------------------------------------------------------------
    logic        hit;
    logic [1:0]  offset;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        div_wr;
    logic        bit_done;
    logic [15:0] divisor_d;
    logic [3:0]  count_field;
    logic [XLEN-1:0] status_word;

    assign hit    = (mmio_control.addr[XLEN-1:4] == BASE_ADDR[XLEN-1:4]);
    assign offset = mmio_control.addr[3:2];
    assign full   = (count_q == c_depth);
    assign empty  = (count_q == '0);

    // A TXDATA write is only refused when the FIFO is full at the start of
    // the cycle; a pop on the same edge does not make room for it.
    assign write_complete = !reset && mmio_control.enable && hit
                            && !((offset == 2'd0) && full);

    assign push   = write_complete && (offset == 2'd0);
    assign div_wr = write_complete && (offset == 2'd2);

    assign divisor_d = (mmio_control.value[15:0] == 16'd0) ? 16'd1
                                                           : mmio_control.value[15:0];

    assign bit_done = (bit_cnt_q == 16'd0);

    // The serializer takes a byte either from IDLE or at the last cycle of
    // a stop bit, so consecutive frames have no idle gap between them.
    assign pop = !empty && ((state_q == S_IDLE) ||
                            ((state_q == S_STOP) && bit_done));

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    assign count_field = 4'(count_q);
    assign status_word = {{(XLEN-12){1'b0}}, count_field, 5'b0,
                          empty, full, (state_q != S_IDLE)};

    always_comb begin
        mmio_r_data = '0;
        if (hit) begin
            case (offset)
                2'd1:    mmio_r_data = status_word;
                2'd2:    mmio_r_data = {{(XLEN-16){1'b0}}, divisor_q};
                default: mmio_r_data = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage (no reset so it can map onto a RAM)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= mmio_control.value[7:0];
        end
    end

    // Pointers wrap naturally since FIFO_DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Divisor register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            divisor_q <= DEFAULT_DIVISOR;
        end else if (div_wr) begin
            divisor_q <= divisor_d;
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM; tx is computed alongside the next state so the line
    // changes on the same edge as the state it belongs to.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            div_act_q <= DEFAULT_DIVISOR;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q   <= fifo_mem_q[rd_ptr_q];
                        div_act_q <= divisor_q;
                        bit_cnt_q <= divisor_q - 16'd1;
                        tx_q      <= 1'b0;
                        state_q   <= S_START;
                    end
                end

                S_START: begin
                    if (bit_done) begin
                        bit_idx_q <= 3'd0;
                        bit_cnt_q <= div_act_q - 16'd1;
                        tx_q      <= shift_q[0];
                        state_q   <= S_DATA;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 16'd1;
                    end
                end

                S_DATA: begin
                    if (bit_done) begin
                        bit_cnt_q <= div_act_q - 16'd1;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            shift_q   <= {1'b0, shift_q[7:1]};
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 16'd1;
                    end
                end

                S_STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            shift_q   <= fifo_mem_q[rd_ptr_q];
                            div_act_q <= divisor_q;
                            bit_cnt_q <= divisor_q - 16'd1;
                            tx_q      <= 1'b0;
                            state_q   <= S_START;
                        end else begin
                            tx_q    <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 16'd1;
                    end
                end

                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx = tx_q;

    // Request fields this responder does not look at.
    logic unused_req_bits;
    assign unused_req_bits = ^{mmio_control.width, mmio_control.addr[1:0],
                               mmio_control.value[XLEN-1:16]};

endmodule : mmio_uart_tx

`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none

// ============================================================================
// Module  : tb_mmio_uart_tx
// Brief   : Scoreboard bench for mmio_uart_tx. Stimulus pushes expected
//           frames into a queue; a tx-line monitor decodes every frame and
//           checks contents, length, start latency and back-to-back spacing.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mmio_uart_tx;
    import mmio_uart_pkg::*;

    localparam logic [31:0] BASE = 32'h0003_0000;

    logic               clock = 1'b0;
    logic               reset;
    mem_write_control_t mmio_control;
    logic [31:0]        mmio_r_data;
    logic               write_complete;
    logic               tx;

    mmio_uart_tx #(
        .BASE_ADDR       (BASE),
        .FIFO_DEPTH      (8),
        .DEFAULT_DIVISOR (16'd434)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mmio_control   (mmio_control),
        .mmio_r_data    (mmio_r_data),
        .write_complete (write_complete),
        .tx             (tx)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] data;
        int         div;
        int         exp_start;   // cycle tx first goes low, -1 = don't care
        bit         b2b;         // must start right after previous stop bit
        bit         may_abort;   // frame may be cut by reset
    } frame_t;

    frame_t exp_q[$];
    bit     mon_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] d, input int div, input int st,
                              input bit b2b, input bit ab);
        frame_t f;
        f.data = d; f.div = div; f.exp_start = st; f.b2b = b2b; f.may_abort = ab;
        exp_q.push_back(f);
    endtask

    // Starts and ends just after a rising edge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] val,
                      output int acc, output int stall);
        mmio_control.enable = 1'b1;
        mmio_control.addr   = addr;
        mmio_control.value  = val;
        mmio_control.width  = 2'd2;
        stall = 0;
        acc   = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (write_complete) begin
                acc = cyc;
                break;
            end
            stall++;
        end
        if (acc < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL write_timeout: addr 0x%0h got no write_complete, expected one within 400 cycles", addr);
        end
        @(posedge clock);
        #1;
        mmio_control.enable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        mmio_control.enable = 1'b0;
        mmio_control.addr   = addr;
        @(negedge clock);
        check(name, mmio_r_data, exp);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !mon_busy) break;
            tick(1);
        end
        check(name, {31'b0, (exp_q.size() == 0 && !mon_busy)}, 32'd1);
    endtask

    // ------------------------------------------------------------------
    // tx monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin
        int prev_end;
        prev_end = -100;
        forever begin
            @(negedge clock);
            if (!reset && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_frame: tx low at cycle %0d, expected idle line", cyc);
                    for (int k = 0; k < 5000 && tx !== 1'b1; k++) @(negedge clock);
                end else begin
                    frame_t f;
                    int     st;
                    int     bad;
                    bit     aborted;
                    f        = exp_q.pop_front();
                    mon_busy = 1'b1;
                    st       = cyc;
                    bad      = 0;
                    aborted  = 1'b0;
                    for (int i = 0; i < 10 * f.div; i++) begin
                        int   slot;
                        logic eb;
                        if (i > 0) @(negedge clock);
                        if (reset) begin
                            aborted = 1'b1;
                            break;
                        end
                        slot = i / f.div;
                        eb   = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : f.data[slot-1];
                        if (tx !== eb) bad++;
                    end
                    if (aborted) begin
                        if (!f.may_abort) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL frame_%02h_aborted: got reset mid-frame, expected full frame", f.data);
                        end
                    end else begin
                        check($sformatf("frame_%02h_bad_cycles", f.data), bad, 0);
                        if (f.exp_start >= 0)
                            check($sformatf("frame_%02h_start_cycle", f.data), st, f.exp_start);
                        if (f.b2b)
                            check($sformatf("frame_%02h_b2b_start", f.data), st, prev_end + 1);
                        prev_end = cyc;
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1ms, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int acc, st, sum, cnt;

        mmio_control = '0;
        reset = 1'b1;
        tick(3);
        mmio_control.enable = 1'b1;
        mmio_control.addr   = BASE;
        mmio_control.value  = 32'h41;
        @(negedge clock);
        check("wc_in_reset", {31'b0, write_complete}, 32'd0);
        check("tx_in_reset", {31'b0, tx}, 32'd1);
        @(posedge clock);
        #1;
        mmio_control.enable = 1'b0;
        reset = 1'b0;

        // Reset state and decode of reads
        rd(BASE + 32'h4, 32'h4, "status_reset");
        rd(BASE + 32'h8, 32'd434, "divisor_reset");
        rd(BASE + 32'h0, 32'h0, "txdata_read");
        rd(BASE + 32'hC, 32'h0, "reserved_read");
        rd(BASE + 32'h104, 32'h0, "read_out_of_window");
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (tx !== 1'b1) cnt++;
        end
        check("tx_idle_100", cnt, 0);
        tick(1);

        // Out-of-window write must not be accepted or enqueued
        mmio_control.enable = 1'b1;
        mmio_control.addr   = BASE + 32'h100;
        mmio_control.value  = 32'h77;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (write_complete) cnt++;
        end
        check("wc_out_of_window", cnt, 0);
        @(posedge clock);
        #1;
        mmio_control.enable = 1'b0;
        rd(BASE + 32'h4, 32'h4, "status_after_miss");

        // Single frame, divisor 4
        wr(BASE + 32'h8, 32'd4, acc, st);
        check("wc_divisor_write", st, 0);
        wr(BASE, 32'h55, acc, st);
        check("wc_single", st, 0);
        push_frame(8'h55, 4, acc + 2, 1'b0, 1'b0);
        rd(BASE + 32'h4, 32'h100, "status_count1");
        rd(BASE + 32'h4, 32'h5, "status_busy");
        wait_drain("drain_single");
        rd(BASE + 32'h4, 32'h4, "status_idle_after_frame");

        // Divisor 0 is stored as 1 -> 10-cycle frame
        wr(BASE + 32'h8, 32'd0, acc, st);
        rd(BASE + 32'h8, 32'd1, "divisor_zero_read");
        wr(BASE, 32'hC3, acc, st);
        push_frame(8'hC3, 1, acc + 2, 1'b0, 1'b0);
        wait_drain("drain_div1");

        // Two bytes back to back
        wr(BASE + 32'h8, 32'd4, acc, st);
        wr(BASE, 32'hA5, acc, st);
        push_frame(8'hA5, 4, acc + 2, 1'b0, 1'b0);
        wr(BASE, 32'h3C, acc, st);
        push_frame(8'h3C, 4, -1, 1'b1, 1'b0);
        wait_drain("drain_b2b");

        // Back-pressure: 9 writes complete, the 10th stalls until a pop
        sum = 0;
        for (int i = 1; i <= 9; i++) begin
            wr(BASE, i, acc, st);
            sum += st;
            push_frame(8'(i), 4, -1, (i > 1), 1'b0);
        end
        check("bp_stall_first9", sum, 0);
        wr(BASE, 32'h0A, acc, st);
        push_frame(8'h0A, 4, -1, 1'b1, 1'b0);
        check("bp_stall_10th", st, 33);
        rd(BASE + 32'h4, 32'h803, "status_full");
        wait_drain("drain_bp");

        // Divisor change mid-frame applies only to the next frame
        wr(BASE, 32'h81, acc, st);
        push_frame(8'h81, 4, acc + 2, 1'b0, 1'b0);
        tick(5);
        wr(BASE + 32'h8, 32'd8, acc, st);
        rd(BASE + 32'h8, 32'd8, "divisor_8_read");
        wr(BASE, 32'h7E, acc, st);
        push_frame(8'h7E, 8, -1, 1'b1, 1'b0);
        wait_drain("drain_div_change");

        // Reset in the middle of a frame
        wr(BASE + 32'h8, 32'd4, acc, st);
        wr(BASE, 32'h0F, acc, st);
        push_frame(8'h0F, 4, acc + 2, 1'b0, 1'b1);
        wr(BASE, 32'hF0, acc, st);
        push_frame(8'hF0, 4, -1, 1'b1, 1'b1);
        tick(12);
        reset = 1'b1;
        mmio_control.enable = 1'b1;
        mmio_control.addr   = BASE;
        mmio_control.value  = 32'h99;
        @(negedge clock);
        check("wc_reset_mid", {31'b0, write_complete}, 32'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("tx_after_reset_edge", {31'b0, tx}, 32'd1);
        @(posedge clock);
        #1;
        mmio_control.enable = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        rd(BASE + 32'h4, 32'h4, "status_after_mid_reset");
        rd(BASE + 32'h8, 32'd434, "divisor_after_mid_reset");
        tick(100);

        check("queue_empty_end", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mmio_uart_tx

`default_nettype wire
